// File: rtl/bin_to_bcd_display.sv
// Iterative double-dabble binary-to-BCD converter that feeds an eight-digit seven-segment driver.
// Define BCD_LEADING_ZERO_BLANK_EN to drive AN_MASK with the leading-zero blanking mask.

module bin_to_bcd_display_chk (
  input logic        clk,
  input logic        rst,
  input logic        busy,
  input logic        done,
  input logic        ovf,
  input logic [31:0] number,
  input logic [7:0]  an_mask
);

  a_done_not_busy: assert property (@(posedge clk) disable iff (rst) !(busy && done));
  a_ovf_saturated: assert property (@(posedge clk) disable iff (rst) ovf |-> (number == 32'hFFFF_FFFF));
  a_ovf_unblanked: assert property (@(posedge clk) disable iff (rst) ovf |-> (an_mask == 8'h00));
  a_digit0_lit:    assert property (@(posedge clk) disable iff (rst) an_mask[0] == 1'b0);

endmodule

module bin_to_bcd_display #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] VALUE,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [31:0]      NUMBER,
  output logic [7:0]       AN_MASK
);

  localparam int             SRW      = 27;
  localparam logic [SRW-1:0] MAX_DEC  = 27'd99_999_999;
  localparam logic [4:0]     CNT_LOAD = 5'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Add 3 to every BCD nibble of 5 or more so the following left shift carries decimally.
  function automatic logic [31:0] dabble_adjust(input logic [31:0] acc);
    logic [31:0] res;
    res = acc;
    for (int i = 0; i < 8; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // Bit i blanks digit i when it and every higher digit are zero; digit 0 is never blanked.
  function automatic logic [7:0] blank_mask(input logic [31:0] num);
    logic [7:0] m;
    logic       zero_above;
    m          = 8'h00;
    zero_above = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_above = zero_above & (num[4*i +: 4] == 4'h0);
      m[i]       = zero_above;
    end
    return m;
  endfunction
`endif

  state_t          state_q, state_d;
  logic [SRW-1:0]  sr_q, sr_d;
  logic [31:0]     acc_q, acc_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            ovf_lat_q, ovf_lat_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     number_q, number_d;
  logic [31:0]     acc_adj;
  logic [SRW-1:0]  value_ext;

  assign acc_adj   = dabble_adjust(acc_q);
  assign value_ext = SRW'(VALUE);

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [7:0] an_mask_q, an_mask_d;
`endif

  // Next-state and datapath logic for the IDLE -> SHIFT -> COMMIT sequence.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_lat_d = ovf_lat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    number_d  = number_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    an_mask_d = an_mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          sr_d      = value_ext;
          acc_d     = 32'h0000_0000;
          cnt_d     = CNT_LOAD;
          ovf_lat_d = (value_ext > MAX_DEC);
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Only the low WIDTH bits hold the operand, so its MSB is taken from bit WIDTH-1.
        acc_d = {acc_adj[30:0], sr_q[WIDTH-1]};
        sr_d  = {sr_q[SRW-2:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        if (ovf_lat_q) begin
          number_d  = 32'hFFFF_FFFF;
`ifdef BCD_LEADING_ZERO_BLANK_EN
          an_mask_d = 8'h00;
`endif
        end else begin
          number_d  = acc_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
          an_mask_d = blank_mask(acc_q);
`endif
        end
        ovf_d   = ovf_lat_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      sr_q      <= {SRW{1'b0}};
      acc_q     <= 32'h0000_0000;
      cnt_q     <= 5'd0;
      ovf_lat_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      number_q  <= 32'h0000_0000;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      an_mask_q <= 8'hFE;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_lat_q <= ovf_lat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      number_q  <= number_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      an_mask_q <= an_mask_d;
`endif
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign OVF    = ovf_q;
  assign NUMBER = number_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign AN_MASK = an_mask_q;
`else
  assign AN_MASK = 8'h00;
`endif

  bin_to_bcd_display_chk u_chk (
    .clk     (clk),
    .rst     (RESET),
    .busy    (BUSY),
    .done    (DONE),
    .ovf     (OVF),
    .number  (NUMBER),
    .an_mask (AN_MASK)
  );

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Randomized bench for bin_to_bcd_display with a decimal-arithmetic reference model.
module tb_bin_to_bcd_display;

  localparam int W = 27;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [7:0] RST_MASK = BLANK ? 8'hFE : 8'h00;

  logic          clk;
  logic          RESET;
  logic          START;
  logic [W-1:0]  VALUE;
  logic          BUSY;
  logic          DONE;
  logic          OVF;
  logic [31:0]   NUMBER;
  logic [7:0]    AN_MASK;

  int n_checks = 0;
  int n_errors = 0;

  bin_to_bcd_display #(.WIDTH(W)) dut (
    .clk     (clk),
    .RESET   (RESET),
    .START   (START),
    .VALUE   (VALUE),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVF     (OVF),
    .NUMBER  (NUMBER),
    .AN_MASK (AN_MASK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of v, least significant digit in the low nibble.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    r = 32'h0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_mask(input int unsigned v);
    logic [7:0] m;
    int nd;
    int unsigned t;
    nd = 1;
    t  = v / 10;
    while (t != 0) begin
      nd++;
      t = t / 10;
    end
    m = 8'h00;
    for (int i = 0; i < 8; i++) m[i] = BLANK && (i >= nd);
    return m;
  endfunction

  function automatic logic [W-1:0] pick_value();
    int unsigned r;
    case ($urandom_range(0, 3))
      0:       r = $urandom_range(0, 9999);
      1:       r = $urandom_range(99999990, 100000010);
      2:       r = $urandom_range(0, 99999999);
      default: r = $urandom & 32'h07FF_FFFF;
    endcase
    return W'(r);
  endfunction

  // Reference model: counts edges since acceptance and commits W+1 edges later.
  logic        m_act;
  int          m_cnt;
  int unsigned m_val;
  logic        e_busy, e_done, e_ovf;
  logic [31:0] e_num;
  logic [7:0]  e_mask;

  always @(posedge clk or posedge RESET) begin
    if (RESET) begin
      m_act  <= 1'b0;
      m_cnt  <= 0;
      m_val  <= 0;
      e_busy <= 1'b0;
      e_done <= 1'b0;
      e_ovf  <= 1'b0;
      e_num  <= 32'h0;
      e_mask <= RST_MASK;
    end else begin
      e_done <= 1'b0;
      if (!m_act) begin
        if (START) begin
          m_act  <= 1'b1;
          m_cnt  <= 0;
          m_val  <= 32'(VALUE);
          e_busy <= 1'b1;
        end
      end else if (m_cnt == W) begin
        m_act  <= 1'b0;
        e_busy <= 1'b0;
        e_done <= 1'b1;
        e_ovf  <= (m_val > 32'd99_999_999);
        e_num  <= (m_val > 32'd99_999_999) ? 32'hFFFF_FFFF : to_bcd(m_val);
        e_mask <= (m_val > 32'd99_999_999) ? 8'h00 : model_mask(m_val);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("busy", 32'(BUSY), 32'(e_busy));
    chk("done", 32'(DONE), 32'(e_done));
    chk("ovf", 32'(OVF), 32'(e_ovf));
    chk("number", NUMBER, e_num);
    chk("an_mask", 32'(AN_MASK), 32'(e_mask));
  endtask

  task automatic start_conv(input logic [W-1:0] v);
    @(negedge clk); #1;
    START = 1'b1;
    VALUE = v;
    @(negedge clk); #1;
    START = 1'b0;
    VALUE = W'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic conv(input logic [W-1:0] v, input logic [31:0] exp_num,
                      input logic [7:0] exp_mask, input logic exp_ovf);
    int cyc;
    start_conv(v);
    wait_done(cyc);
    chk("latency", 32'(cyc), 32'd28);
    chk("lit_number", NUMBER, exp_num);
    chk("lit_an_mask", 32'(AN_MASK), 32'(exp_mask));
    chk("lit_ovf", 32'(OVF), 32'(exp_ovf));
    chk("lit_busy_low", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int cyc;
    logic seen;
    START = 1'b0;
    VALUE = '0;
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    #1 RESET = 1'b0;
    chk("rst_number", NUMBER, 32'h0);
    chk("rst_an_mask", 32'(AN_MASK), 32'(RST_MASK));
    chk("rst_busy", 32'(BUSY), 32'd0);
    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    conv(27'd12_345_678, 32'h1234_5678, 8'h00, 1'b0);
    conv(27'd1005, 32'h0000_1005, BLANK ? 8'hF0 : 8'h00, 1'b0);
    conv(27'd0, 32'h0000_0000, RST_MASK, 1'b0);
    conv(27'd99_999_999, 32'h9999_9999, 8'h00, 1'b0);
    conv(27'd100_000_000, 32'hFFFF_FFFF, 8'h00, 1'b1);

    // START while busy is ignored; START in the DONE cycle is accepted.
    start_conv(27'd42);
    repeat (3) @(negedge clk);
    #1 START = 1'b1;
    VALUE = 27'd7;
    @(negedge clk); #1;
    START = 1'b0;
    wait_done(cyc);
    chk("busy_start_latency", 32'(cyc), 32'd24);
    chk("num_42", NUMBER, 32'h0000_0042);
    START = 1'b1;
    VALUE = 27'd7;
    @(negedge clk); #1;
    START = 1'b0;
    wait_done(cyc);
    chk("b2b_latency", 32'(cyc), 32'd28);
    chk("num_7", NUMBER, 32'h0000_0007);

    // Reset mid-conversion takes effect before the next clock edge.
    start_conv(27'd555);
    repeat (9) @(negedge clk);
    #1 RESET = 1'b1;
    #1;
    chk("async_number", NUMBER, 32'h0);
    chk("async_an_mask", 32'(AN_MASK), 32'(RST_MASK));
    chk("async_busy", 32'(BUSY), 32'd0);
    chk("async_done", 32'(DONE), 32'd0);
    chk("async_ovf", 32'(OVF), 32'd0);
    @(negedge clk); #1;
    RESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      seen = seen | DONE;
    end
    chk("no_done_after_reset", 32'(seen), 32'd0);
    conv(27'd555, 32'h0000_0555, BLANK ? 8'hF8 : 8'h00, 1'b0);

    for (int c = 0; c < 2500; c++) begin
      @(negedge clk); #1;
      START = ($urandom_range(0, 2) == 0);
      VALUE = pick_value();
      RESET = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); #1;
    RESET = 1'b0;
    START = 1'b0;
    repeat (35) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
